// File: rtl/note_display_scanner.sv
// Scrolling multi-digit note display driver.
//
// Keeps DIGITS note codes in a shift buffer (slot 0 = rightmost/newest) and time-multiplexes them
// onto a shared 7-segment bus. Notes arrive over a valid/ready handshake; an optional hold timer
// paces entry by dropping note_ready_o for HOLD_CYCLES cycles after each accept.
//
// Ports
//   clk_i         single clock, all state on the rising edge
//   reset_i       synchronous, active-high reset
//   clear_i       synchronous clear of the note buffer and the hold FSM
//   note_valid_i  note_code_i is valid
//   note_code_i   [3] = sharp, [2:0] = 0..6 -> C D E F G A B, 7 -> rest
//   note_ready_o  block can accept a note (registered)
//   seg_o         {g,f,e,d,c,b,a} of the selected digit (registered)
//   dp_o          sharp indicator of the selected digit (registered)
//   an_o          one-hot digit enable (registered)
module note_display_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              note_valid_i,
  input  logic [3:0]        note_code_i,
  output logic              note_ready_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam bit          HoldEn = (HOLD_CYCLES > 0);

  localparam logic [DivW-1:0]   DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(DIGITS - 1);
  localparam logic [HoldW-1:0]  HoldLoad = HoldEn ? HoldW'(HOLD_CYCLES - 1) : '0;
  // Reset output image: digit 0 enabled, segments and dp dark, all after polarity.
  localparam logic [DIGITS-1:0] AnRst    = {{(DIGITS-1){ACTIVE_LOW}}, ~ACTIVE_LOW};
  localparam logic [6:0]        SegRst   = {7{ACTIVE_LOW}};

  typedef struct packed {
    logic       used;
    logic [3:0] code;
  } slot_t;

  typedef enum logic [0:0] {StReady, StHold} state_e;

  slot_t [DIGITS-1:0] slot_q, slot_d;
  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               ready_q, ready_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [DIGITS-1:0]  an_q, an_d;

  logic               accept;
  slot_t              sel;
  logic [6:0]         seg_pre;
  logic               dp_pre;
  logic [DIGITS-1:0]  an_pre;

  assign accept = note_valid_i & ready_q;

  function automatic logic [6:0] note_to_seg(input logic [2:0] note);
    logic [6:0] s;
    unique case (note)
      3'd0:    s = 7'h39;  // C
      3'd1:    s = 7'h5E;  // D
      3'd2:    s = 7'h79;  // E
      3'd3:    s = 7'h71;  // F
      3'd4:    s = 7'h3D;  // G
      3'd5:    s = 7'h77;  // A
      3'd6:    s = 7'h7C;  // B
      default: s = 7'h40;  // rest: dash
    endcase
    return s;
  endfunction

  // Note buffer: clear wins over accept, so a coinciding handshake is consumed and dropped.
  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = '0;
    end else if (accept) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = '{used: 1'b1, code: note_code_i};
    end
  end

  // Hold FSM: READY counts HOLD_CYCLES-1 down to 0 in HOLD, giving HOLD_CYCLES low cycles.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (clear_i) begin
      state_d = StReady;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StReady: begin
          if (accept && HoldEn) begin
            state_d = StHold;
            hold_d  = HoldLoad;
          end
        end
        StHold: begin
          if (hold_q == '0) begin
            state_d = StReady;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: begin
          state_d = StReady;
          hold_d  = '0;
        end
      endcase
    end
    ready_d = (state_d == StReady);
  end

  // Scanner: free-running, independent of clear and the handshake.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivLast) begin
      div_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Output decode of the currently selected slot; registered below for 1-cycle latency.
  always_comb begin
    sel     = slot_q[idx_q];
    seg_pre = '0;
    dp_pre  = 1'b0;
    if (sel.used) begin
      seg_pre = note_to_seg(sel.code[2:0]);
      dp_pre  = sel.code[3] && (sel.code[2:0] != 3'd7);
    end
    an_pre        = '0;
    an_pre[idx_q] = 1'b1;
    seg_d = seg_pre ^ {7{ACTIVE_LOW}};
    dp_d  = dp_pre ^ ACTIVE_LOW;
    an_d  = an_pre ^ {DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_q  <= '0;
      state_q <= StReady;
      hold_q  <= '0;
      ready_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SegRst;
      dp_q    <= ACTIVE_LOW;
      an_q    <= AnRst;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign note_ready_o = ready_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;

endmodule

// File: tb/tb_note_display_scanner.sv
// Directed bench for note_display_scanner. Three instances share the clock, reset, clear and code:
//   u0: HOLD_CYCLES=0, ACTIVE_LOW=0    u1: HOLD_CYCLES=3, ACTIVE_LOW=0
//   u2: HOLD_CYCLES=3, ACTIVE_LOW=1 (same inputs as u1, so it tracks u1 with inverted pins)
module tb_note_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [3:0] code = 4'h0;

  logic       rdy0, rdy1, rdy2;
  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [3:0] an0, an1, an2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .HOLD_CYCLES(0), .ACTIVE_LOW(1'b0)) u0 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .note_valid_i(v0), .note_code_i(code),
    .note_ready_o(rdy0), .seg_o(seg0), .dp_o(dp0), .an_o(an0)
  );

  note_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .HOLD_CYCLES(3), .ACTIVE_LOW(1'b0)) u1 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .note_valid_i(v1), .note_code_i(code),
    .note_ready_o(rdy1), .seg_o(seg1), .dp_o(dp1), .an_o(an1)
  );

  note_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .HOLD_CYCLES(3), .ACTIVE_LOW(1'b1)) u2 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .note_valid_i(v1), .note_code_i(code),
    .note_ready_o(rdy2), .seg_o(seg2), .dp_o(dp2), .an_o(an2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until the chosen instance enables the target digit; a timeout shows up as a failed check.
  task automatic wait_an(input int which, input logic [3:0] target);
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((which == 0 ? an0 : an1) == target) break;
    end
    check("wait_an", (which == 0) ? an0 : an1, target);
  endtask

  initial begin
    logic [3:0] exp_an;

    // Reset held for three edges.
    tick(); tick(); tick();
    check("rst_ready", rdy0, 1'b0);
    check("rst_an", an0, 4'b0001);
    check("rst_seg", seg0, 7'h00);
    check("rst_dp", dp0, 1'b0);
    reset = 1'b0;
    tick();
    check("rel_ready", rdy0, 1'b1);
    check("scan_an", an0, 4'b0001);

    // Scan order with SCAN_DIV=4: each digit held for exactly four cycles.
    for (int n = 5; n <= 23; n++) begin
      tick();
      exp_an = 4'b0001 << (((n - 4) / 4) % 4);
      check("scan_an", an0, exp_an);
    end

    // Back-to-back accepts with no pacing: C, D#, G, rest.
    v0 = 1'b1;
    code = 4'h0; tick();
    code = 4'h9; tick();
    code = 4'h4; tick();
    check("nohold_ready", rdy0, 1'b1);
    code = 4'h7; tick();
    v0 = 1'b0;
    wait_an(0, 4'b0001);
    check("d0_seg", seg0, 7'h40);
    check("d0_dp", dp0, 1'b0);
    wait_an(0, 4'b0010);
    check("d1_seg", seg0, 7'h3D);
    check("d1_dp", dp0, 1'b0);
    wait_an(0, 4'b0100);
    check("d2_seg", seg0, 7'h5E);
    check("d2_dp", dp0, 1'b1);
    wait_an(0, 4'b1000);
    check("d3_seg", seg0, 7'h39);
    check("d3_dp", dp0, 1'b0);

    // Clear together with a valid note: buffer blanks and the note is dropped.
    clear = 1'b1; v0 = 1'b1; code = 4'h5;
    tick();
    clear = 1'b0; v0 = 1'b0;
    check("clr_ready", rdy0, 1'b1);
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b0001 << d;
      wait_an(0, exp_an);
      check("clr_seg", seg0, 7'h00);
      check("clr_dp", dp0, 1'b0);
    end

    // Pacing with HOLD_CYCLES=3 and valid held high: ready low three cycles, high one.
    code = 4'h2; v1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) code = 4'hB;
      check("hold_ready1", rdy1, (k % 4) == 3);
      check("hold_ready2", rdy2, (k % 4) == 3);
    end
    v1 = 1'b0;
    // Exactly two notes taken: slot0 = F#, slot1 = E, the rest blank.
    wait_an(1, 4'b0001);
    check("h0_seg", seg1, 7'h71);
    check("h0_dp", dp1, 1'b1);
    check("al_an", an2, 4'b1110);
    check("al_seg", seg2, 7'h0E);
    check("al_dp", dp2, 1'b0);
    wait_an(1, 4'b0010);
    check("h1_seg", seg1, 7'h79);
    check("h1_dp", dp1, 1'b0);
    wait_an(1, 4'b0100);
    check("h2_seg", seg1, 7'h00);

    // Reset in the middle of HOLD on the active-low instance.
    v1 = 1'b1;
    tick();
    check("enter_hold", rdy2, 1'b0);
    v1 = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_an", an2, 4'b1110);
    check("midrst_seg", seg2, 7'h7F);
    check("midrst_dp", dp2, 1'b1);
    check("midrst_ready", rdy2, 1'b0);
    reset = 1'b0;
    tick();
    check("post_ready", rdy2, 1'b1);
    check("post_an", an2, 4'b1110);
    check("post_seg", seg2, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
